// File: rtl/cpu_stack_if.sv
// Request/response bundle for cpu_stack: the control unit drives requests as master,
// the stack answers as slave.
interface cpu_stack_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) ();
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic              peek;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;
  logic [DATA_W-1:0] pop_out;
  logic              push_done;
  logic              pop_done;
  logic [PTR_W-1:0]  sp;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, peek, push_data, err_clr,
    input  pop_out, push_done, pop_done, sp, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, peek, push_data, err_clr,
    output pop_out, push_done, pop_done, sp, full, empty, overflow, underflow
  );
endinterface

// File: rtl/cpu_stack.sv
// Parametrised LIFO stack with push/pop/exchange, sticky overflow/underflow flags.
// Optional top-of-stack peek is enabled by defining CPU_STACK_PEEK_EN.
module cpu_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  cpu_stack_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_XCHG,
    OP_PEEK
  } op_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [DATA_W-1:0] pop_out_q, pop_out_d;
  logic              push_done_q, push_done_d;
  logic              pop_done_q, pop_done_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  op_e               op;
  logic              full, empty;
  logic              ovf_ev, unf_ev;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [AW-1:0]     top_idx;

  assign full    = (sp_q == PTR_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = AW'(sp_q - PTR_W'(1));

  // Request priority: push+pop pair, then single push or pop, then peek.
  always_comb begin
    op = OP_NONE;
    if (bus.push && bus.pop) op = OP_XCHG;
    else if (bus.push)       op = OP_PUSH;
    else if (bus.pop)        op = OP_POP;
`ifdef CPU_STACK_PEEK_EN
    else if (bus.peek)       op = OP_PEEK;
`endif
  end

`ifndef CPU_STACK_PEEK_EN
  logic unused_peek;
  assign unused_peek = bus.peek;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    sp_d        = sp_q;
    pop_out_d   = pop_out_q;
    push_done_d = 1'b0;
    pop_done_d  = 1'b0;
    ovf_ev      = 1'b0;
    unf_ev      = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = top_idx;
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_ev = 1'b1;
        end else begin
          mem_we      = 1'b1;
          mem_wa      = AW'(sp_q);
          sp_d        = sp_q + PTR_W'(1);
          push_done_d = 1'b1;
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_ev = 1'b1;
        end else begin
          pop_out_d  = mem[top_idx];
          sp_d       = sp_q - PTR_W'(1);
          pop_done_d = 1'b1;
        end
      end
      OP_XCHG: begin
        // Empty exchange passes the pushed word straight through without storing it.
        push_done_d = 1'b1;
        pop_done_d  = 1'b1;
        if (empty) begin
          pop_out_d = bus.push_data;
        end else begin
          pop_out_d = mem[top_idx];
          mem_we    = 1'b1;
        end
      end
`ifdef CPU_STACK_PEEK_EN
      OP_PEEK: begin
        if (empty) begin
          unf_ev = 1'b1;
        end else begin
          pop_out_d  = mem[top_idx];
          pop_done_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    // A same-cycle error event beats err_clr.
    overflow_d  = ovf_ev | (overflow_q  & ~bus.err_clr);
    underflow_d = unf_ev | (underflow_q & ~bus.err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sp_q        <= '0;
      pop_out_q   <= '0;
      push_done_q <= 1'b0;
      pop_done_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      pop_out_q   <= pop_out_d;
      push_done_q <= push_done_d;
      pop_done_q  <= pop_done_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= bus.push_data;
  end

  assign bus.sp        = sp_q;
  assign bus.pop_out   = pop_out_q;
  assign bus.push_done = push_done_q;
  assign bus.pop_done  = pop_done_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
endmodule

// File: tb/tb_cpu_stack.sv
// Directed bench for cpu_stack (DEPTH=4): queue-based reference model checked every
// cycle, plus literal expectations along the test plan.
module tb_cpu_stack;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  cpu_stack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  cpu_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue whose back is the top of stack.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_out;
  logic m_push_done, m_pop_done, m_ovf, m_unf;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_q.delete();
      m_out = '0; m_push_done = 0; m_pop_done = 0; m_ovf = 0; m_unf = 0;
    end else begin
      logic ovf_ev, unf_ev;
      ovf_ev = 0; unf_ev = 0;
      m_push_done = 0; m_pop_done = 0;
      if (bus.push && bus.pop) begin
        m_push_done = 1; m_pop_done = 1;
        if (m_q.size() == 0) m_out = bus.push_data;
        else begin
          m_out = m_q[$];
          m_q[m_q.size()-1] = bus.push_data;
        end
      end else if (bus.push) begin
        if (m_q.size() == DEPTH) ovf_ev = 1;
        else begin m_q.push_back(bus.push_data); m_push_done = 1; end
      end else if (bus.pop) begin
        if (m_q.size() == 0) unf_ev = 1;
        else begin m_out = m_q.pop_back(); m_pop_done = 1; end
      end
`ifdef CPU_STACK_PEEK_EN
      else if (bus.peek) begin
        if (m_q.size() == 0) unf_ev = 1;
        else begin m_out = m_q[$]; m_pop_done = 1; end
      end
`endif
      m_ovf = ovf_ev | (m_ovf & ~bus.err_clr);
      m_unf = unf_ev | (m_unf & ~bus.err_clr);
    end
  end

  always @(negedge clk) begin
    check("sp",        32'(bus.sp),        32'(m_q.size()));
    check("full",      32'(bus.full),      32'(m_q.size() == DEPTH));
    check("empty",     32'(bus.empty),     32'(m_q.size() == 0));
    check("pop_out",   32'(bus.pop_out),   32'(m_out));
    check("push_done", 32'(bus.push_done), 32'(m_push_done));
    check("pop_done",  32'(bus.pop_done),  32'(m_pop_done));
    check("overflow",  32'(bus.overflow),  32'(m_ovf));
    check("underflow", 32'(bus.underflow), 32'(m_unf));
  end

  task automatic step(input logic pu, input logic po, input logic pk,
                      input logic [DATA_W-1:0] d, input logic clr);
    bus.push = pu; bus.pop = po; bus.peek = pk; bus.push_data = d; bus.err_clr = clr;
    @(posedge clk);
    @(negedge clk);
    bus.push = 0; bus.pop = 0; bus.peek = 0; bus.push_data = '0; bus.err_clr = 0;
  endtask

  task automatic push_v(input logic [DATA_W-1:0] d); step(1, 0, 0, d, 0); endtask
  task automatic pop_v();                           step(0, 1, 0, '0, 0); endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " sp"},        32'(bus.sp),        0);
    check({tag, " pop_out"},   32'(bus.pop_out),   0);
    check({tag, " push_done"}, 32'(bus.push_done), 0);
    check({tag, " pop_done"},  32'(bus.pop_done),  0);
    check({tag, " overflow"},  32'(bus.overflow),  0);
    check({tag, " underflow"}, 32'(bus.underflow), 0);
    check({tag, " empty"},     32'(bus.empty),     1);
    check({tag, " full"},      32'(bus.full),      0);
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; bus.peek = 0; bus.push_data = '0; bus.err_clr = 0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_b = 1'b1;

    // Basic LIFO ordering
    push_v(16'h1111); check("push1 done", 32'(bus.push_done), 1);
    push_v(16'h2222);
    push_v(16'h3333); check("sp after 3 pushes", 32'(bus.sp), 3);
    pop_v(); check("pop1", 32'(bus.pop_out), 16'h3333); check("pop1 done", 32'(bus.pop_done), 1);
    pop_v(); check("pop2", 32'(bus.pop_out), 16'h2222);
    pop_v(); check("pop3", 32'(bus.pop_out), 16'h1111);
    check("sp after pops", 32'(bus.sp), 0); check("empty after pops", 32'(bus.empty), 1);
    step(0, 0, 0, '0, 0); check("pop_done single pulse", 32'(bus.pop_done), 0);

    // Fill, overflow, clear, exchange while full
    push_v(16'h1001); push_v(16'h1002); push_v(16'h1003);
    check("not full at 3", 32'(bus.full), 0);
    push_v(16'h1004); check("full at 4", 32'(bus.full), 1);
    push_v(16'h1005);
    check("overflow push_done", 32'(bus.push_done), 0);
    check("overflow flag", 32'(bus.overflow), 1);
    check("overflow sp", 32'(bus.sp), 4);
    pop_v(); check("pop after overflow", 32'(bus.pop_out), 16'h1004);
    check("overflow sticky", 32'(bus.overflow), 1);
    step(0, 0, 0, '0, 1); check("overflow cleared", 32'(bus.overflow), 0);
    push_v(16'h1007);
    step(1, 1, 0, 16'h1008, 0);
    check("xchg full pop_out", 32'(bus.pop_out), 16'h1007);
    check("xchg full no overflow", 32'(bus.overflow), 0);
    check("xchg full sp", 32'(bus.sp), 4);
    pop_v(); check("pop xchg value", 32'(bus.pop_out), 16'h1008);
    pop_v(); pop_v(); pop_v(); check("drain last", 32'(bus.pop_out), 16'h1001);

    // Underflow
    pop_v();
    check("underflow flag", 32'(bus.underflow), 1);
    check("underflow no pop_done", 32'(bus.pop_done), 0);
    check("underflow pop_out held", 32'(bus.pop_out), 16'h1001);
    step(0, 1, 0, '0, 1); check("underflow wins over clr", 32'(bus.underflow), 1);
    step(0, 0, 0, '0, 1); check("underflow cleared", 32'(bus.underflow), 0);

    // Exchange and empty pass-through
    push_v(16'h9999); push_v(16'hAAAA);
    step(1, 1, 0, 16'hBBBB, 0);
    check("xchg pop_out", 32'(bus.pop_out), 16'hAAAA);
    check("xchg sp", 32'(bus.sp), 2);
    check("xchg both done", 32'({bus.push_done, bus.pop_done}), 2'b11);
    pop_v(); check("pop after xchg", 32'(bus.pop_out), 16'hBBBB);
    pop_v(); check("pop bottom", 32'(bus.pop_out), 16'h9999);
    step(1, 1, 0, 16'h5A5A, 0);
    check("pass-through pop_out", 32'(bus.pop_out), 16'h5A5A);
    check("pass-through sp", 32'(bus.sp), 0);
    check("pass-through no underflow", 32'(bus.underflow), 0);

    // Peek
    push_v(16'h1234);
    step(0, 0, 1, '0, 0);
`ifdef CPU_STACK_PEEK_EN
    check("peek pop_out", 32'(bus.pop_out), 16'h1234);
    check("peek pop_done", 32'(bus.pop_done), 1);
`else
    check("peek ignored pop_out", 32'(bus.pop_out), 16'h5A5A);
    check("peek ignored pop_done", 32'(bus.pop_done), 0);
`endif
    check("peek sp", 32'(bus.sp), 1);
    pop_v(); check("pop after peek", 32'(bus.pop_out), 16'h1234);
    step(0, 0, 1, '0, 0);
`ifdef CPU_STACK_PEEK_EN
    check("peek empty underflow", 32'(bus.underflow), 1);
`else
    check("peek empty ignored", 32'(bus.underflow), 0);
`endif
    step(0, 0, 0, '0, 1);

    // Asynchronous reset in the middle of a push burst
    push_v(16'h0001); push_v(16'h0002);
    bus.push = 1; bus.push_data = 16'h0003;
    @(posedge clk);
    bus.push_data = 16'h0004;
    #2 rst_b = 1'b0;
    #1 check_reset_vals("async reset");
    @(negedge clk);
    bus.push = 0; bus.push_data = '0;
    @(negedge clk);
    rst_b = 1'b1;
    step(0, 0, 0, '0, 0);
    check("no push_done after reset", 32'(bus.push_done), 0);
    check("sp after reset", 32'(bus.sp), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_stack.md
# cpu_stack

Parametrised hardware LIFO stack unit for the CPU datapath, serving the control unit's push/pop requests (return addresses, saved registers). It generalises the fixed 16-bit stack handshake (push/pop with `push_done`/`pop_done`) to configurable data width and depth. It adds full/empty status, a stack-pointer readout, simultaneous push+pop exchange and sticky overflow/underflow error flags.

## Interface

- `DATA_W`, default 16: width of each stack entry.
- `DEPTH`, default 16: number of entries; any value ≥ 2.
- `PTR_W`, default `$clog2(DEPTH+1)`: width of the `sp` count output (derived, not overridden).

Ports:

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `push` in 1: push request, sampled each rising edge.
- `pop` in 1: pop request, sampled each rising edge.
- `peek` in 1: read top without removal; honoured only when `CPU_STACK_PEEK_EN` is defined.
- `push_data` in `DATA_W`: data to push.
- `err_clr` in 1: clears sticky error flags.
- `pop_out` out `DATA_W`: registered popped/peeked data.
- `push_done` out 1: one-cycle pulse, push accepted.
- `pop_done` out 1: one-cycle pulse, `pop_out` updated.
- `sp` out `PTR_W`: current entry count, 0..`DEPTH`.
- `full` out 1: `sp == DEPTH`.
- `empty` out 1: `sp == 0`.
- `overflow` out 1: sticky, push attempted while full.
- `underflow` out 1: sticky, pop/peek attempted while empty.

## Operation

- Storage: `DEPTH` x `DATA_W` register array; the top entry is at index `sp-1`. The array is not reset.
- Requests are evaluated per edge with priority: push+pop pair, then push or pop, then peek. `peek` is ignored when `push` or `pop` is high.
- Push only, `!full`: `mem[sp] <= push_data`, `sp <= sp+1`, `push_done` pulses.
- Push only, `full`: no write, `sp` unchanged, `push_done` stays low, `overflow <= 1`.
- Pop only, `!empty`: `pop_out <= mem[sp-1]`, `sp <= sp-1`, `pop_done` pulses.
- Pop only, `empty`: `pop_out` holds, `pop_done` stays low, `underflow <= 1`.
- Push+pop, `!empty` (exchange): `pop_out <= mem[sp-1]`, `mem[sp-1] <= push_data`, `sp` unchanged, both done signals pulse. Valid when full; no overflow.
- Push+pop, `empty` (pass-through): `pop_out <= push_data`, no write, `sp` stays 0, both done signals pulse, no underflow.
- `err_clr` clears `overflow` and `underflow`. An error event in the same cycle wins, so the flag is set.
- Status: `full`, `empty` are combinational from `sp`. `sp` never wraps.

## Timing

- Reset values while `rst_b` is low: `sp=0`, `pop_out=0`, `push_done=0`, `pop_done=0`, `overflow=0`, `underflow=0`. Consequently `empty=1`, `full=0`.
- Reset mid-operation aborts any request in flight; no done pulse is produced afterwards.
- Latency: a request sampled at edge N gives updated `sp`, `pop_out` and done pulses valid after edge N (visible in cycle N+1). Done pulses last exactly one cycle.
- Back-to-back requests every cycle are sustained; throughput is one operation per clock.
- A pop in cycle N+1 returns data pushed at edge N; no bypass stall is needed.
- Requests are level-sampled: a request held high for k cycles counts as k operations.

## Configuration

- `CPU_STACK_PEEK_EN` defined: `peek` high with `push=pop=0` causes:
  - `!empty`: `pop_out <= mem[sp-1]`, `pop_done` pulses, `sp` unchanged.
  - `empty`: `underflow <= 1`, no pulse.
- `CPU_STACK_PEEK_EN` undefined: the `peek` port exists but is ignored, and no peek logic is synthesised.

## Test plan

- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop three times -> pops return 0x3333, 0x2222, 0x1111; `push_done`/`pop_done` one pulse each; `sp` goes 3 then 0; `empty=1`.
- `DEPTH=4`: push 5 values -> `full=1` after the 4th; 5th gives no `push_done`, `overflow=1`, `sp=4`. Pop returns the 4th value. `err_clr` -> `overflow=0`.
- Pop on empty -> `underflow=1`, no `pop_done`, `pop_out` unchanged. `err_clr` held with a simultaneous empty pop -> `underflow` stays 1.
- `sp=2` with top 0xAAAA, push 0xBBBB + pop together -> `pop_out=0xAAAA`, `sp=2`, next pop returns 0xBBBB. With empty stack, push 0x5A5A + pop -> `pop_out=0x5A5A`, `sp=0`.
- Push three values, assert `rst_b` low mid-push -> all outputs at reset values immediately (asynchronous); no done pulse after release.
- `CPU_STACK_PEEK_EN` defined, top 0x1234 -> `peek` returns 0x1234 with a `pop_done` pulse and `sp` unchanged. Macro undefined -> `peek` produces no change.
